div_sequencer: RTL and testbench
================================

// Module: div_sequencer
// PURPOSE
//  Iterative, multi-cycle integer divider controller for the execute stage. Replaces the combinational
//  div/udiv pair and the fixed divide delay counter with a start/result handshake.
//  Execute holds its pipeline while result_valid is low.
//  Computes quotient and remainder, signed (truncating, as SV $signed '/') or unsigned.
// PARAMETERS
//  WIDTH       32  operand/result width
//  RADIX_BITS  1   quotient bits retired per Iterate cycle; legal 1,2,4; WIDTH % RADIX_BITS == 0
// PORTS
//  clock           in   1      sole clock, rising edge
//  reset_n         in   1      asynchronous, active-low reset
//  start_valid     in   1      request a divide; accepted when start_valid && start_ready
//  start_ready     out  1      high only in Idle
//  is_signed       in   1      1 = signed divide, 0 = unsigned; sampled on accept
//  numer           in   WIDTH  dividend; sampled on accept
//  denom           in   WIDTH  divisor; sampled on accept
//  flush           in   1      abort any operation in flight
//  result_valid    out  1      quotient/remainder/divide_by_zero valid
//  result_ready    in   1      consumer takes result when result_valid && result_ready
//  quotient        out  WIDTH  registered
//  remainder       out  WIDTH  registered
//  divide_by_zero  out  1      denom was 0
// BEHAVIOUR
//  - Reset: state=Idle; result_valid=0; quotient=0; remainder=0; divide_by_zero=0.
//    start_ready=1, decoded from Idle.
//  - Accept: operands, is_signed, and the signs of numer and of (numer^denom) are latched.
//  - States and transitions:
//    - Idle -> Prepare: on accept.
//    - Prepare: absolute values are formed when is_signed; N=WIDTH/RADIX_BITS loaded to the step counter.
//      - If denom==0 -> Done with quotient={WIDTH{1}}, remainder=numer (unmodified), divide_by_zero=1.
//      - Otherwise -> Iterate.
//    - Iterate: one restoring step of RADIX_BITS bits per cycle; counter decrements; counter==1 -> Fixup.
//    - Fixup: quotient is negated iff signed && signs differ; remainder is negated iff signed && numer negative.
//      Then -> Done.
//    - Done: result_valid=1; outputs held stable; result_ready -> Idle on the same edge.
//  - Latency, accept edge to result_valid high:
//    - normal: N+2 cycles (34 for defaults)
//    - divide-by-zero: 2 cycles
//  - No overlap: a new start is accepted only from Idle, i.e. one cycle after the result is taken.
//  - Arithmetic: partial remainder is WIDTH+1 bits. 0x80000000 / -1 signed -> q=0x80000000, r=0 (no trap).
//  - flush, any state: next edge -> Idle, result_valid=0, datapath registers don't-care.
//    flush wins over a simultaneous start_valid or result_ready.
//  - Asynchronous reset mid-operation: immediate return to reset values; the operation is lost.
// CONFIGURATION
//  DIV_EARLY_OUT_EN defined:
//   - In Prepare, |denom| > |numer| (unsigned magnitude compare) -> Fixup with q=0, r=|numer|.
//   - Latency 3 cycles; sign fix-up still applies.
//  DIV_EARLY_OUT_EN undefined: no compare logic; every non-zero divisor takes N+2 cycles.
// STRUCTURE
//  - Shared package: divseq_state_t enum (Idle, Prepare, Iterate, Fixup, Done); default DIV_WIDTH constant.
//    Execute stage reuses the same constant for its operation decode.
//  - Sub-module div_step: combinational, one RADIX_BITS-bit restoring step.
//    (rem_in, quo_in, divisor) -> (rem_out, quo_out); instantiated once.
// TESTING
//  - Unsigned 100/7: q=14, r=2, dz=0; result_valid exactly 34 cycles after accept.
//  - Signed -7/2: q=0xFFFFFFFD, r=0xFFFFFFFF. Signed 7/-2: q=0xFFFFFFFD, r=1.
//  - Signed 0x80000000 / 0xFFFFFFFF: q=0x80000000, r=0. Unsigned same operands: q=0, r=0x80000000.
//  - Divide by zero, numer=0x1234: q=0xFFFFFFFF, r=0x1234, dz=1; result_valid after 2 cycles.
//  - flush at cycle 10 of Iterate: result_valid never rises; start_ready=1 next cycle.
//    Next op 9/3 -> q=3, r=0.
//  - result_ready low for 5 cycles in Done: outputs stable, start_ready=0.
//    reset_n pulsed mid-Iterate: all outputs at reset values immediately.
//  - With DIV_EARLY_OUT_EN, unsigned 5/9: q=0, r=5 after 3 cycles. Without it: same result after 34 cycles.

Source files
------------

// File: rtl/div_sequencer_pkg.sv
// Shared divider definitions: default operand width and the sequencer state encoding.
package div_sequencer_pkg;

  localparam int unsigned DIV_WIDTH = 32;

  typedef enum logic [2:0] {
    DIVSEQ_IDLE    = 3'd0,
    DIVSEQ_PREPARE = 3'd1,
    DIVSEQ_ITERATE = 3'd2,
    DIVSEQ_FIXUP   = 3'd3,
    DIVSEQ_DONE    = 3'd4
  } divseq_state_t;

endpackage

// File: rtl/div_sequencer_div_step.sv
// One combinational restoring-division step retiring RADIX_BITS quotient bits.
module div_step
  import div_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH      = DIV_WIDTH,
  parameter int unsigned RADIX_BITS = 1
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0]   r_c;
  logic [WIDTH-1:0] q_c;

  // Dividend bits shift out of the top of quo as quotient bits shift in at the bottom.
  always_comb begin
    r_c = rem_in;
    q_c = quo_in;
    for (int i = 0; i < int'(RADIX_BITS); i++) begin
      r_c = {r_c[WIDTH-1:0], q_c[WIDTH-1]};
      q_c = {q_c[WIDTH-2:0], 1'b0};
      if (r_c >= {1'b0, divisor}) begin
        r_c    = r_c - {1'b0, divisor};
        q_c[0] = 1'b1;
      end
    end
    rem_out = r_c;
    quo_out = q_c;
  end

endmodule

// File: rtl/div_sequencer.sv
// Iterative signed/unsigned divider with start/result handshake.
// Optional DIV_EARLY_OUT_EN: skip iteration when |denom| > |numer|.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH      = DIV_WIDTH,
  parameter int unsigned RADIX_BITS = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] numer,
  input  logic [WIDTH-1:0] denom,
  input  logic             flush,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             divide_by_zero
);

  localparam int unsigned STEPS = WIDTH / RADIX_BITS;
  localparam int unsigned CNT_W = $clog2(STEPS + 1);

  divseq_state_t    state_q, state_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sgn_q, sgn_d;
  logic             neg_n_q, neg_n_d;
  logic             neg_diff_q, neg_diff_d;
  logic             dz_q, dz_d;
  logic             early_q, early_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dz_out_q, dz_out_d;
  logic             valid_q, valid_d;
  logic             ready_q, ready_d;

  logic [WIDTH:0]   step_rem_c;
  logic [WIDTH-1:0] step_quo_c;
  logic [WIDTH-1:0] abs_n_c;
  logic [WIDTH-1:0] abs_d_c;

  // quo_q/div_q still hold the raw operands while in Prepare
  assign abs_n_c = (sgn_q && neg_n_q)      ? -quo_q : quo_q;
  assign abs_d_c = (sgn_q && div_q[WIDTH-1]) ? -div_q : div_q;

  div_step #(
    .WIDTH      (WIDTH),
    .RADIX_BITS (RADIX_BITS)
  ) u_div_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (div_q),
    .rem_out (step_rem_c),
    .quo_out (step_quo_c)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= DIVSEQ_IDLE;
      rem_q       <= '0;
      quo_q       <= '0;
      div_q       <= '0;
      cnt_q       <= '0;
      sgn_q       <= 1'b0;
      neg_n_q     <= 1'b0;
      neg_diff_q  <= 1'b0;
      dz_q        <= 1'b0;
      early_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dz_out_q    <= 1'b0;
      valid_q     <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      sgn_q       <= sgn_d;
      neg_n_q     <= neg_n_d;
      neg_diff_q  <= neg_diff_d;
      dz_q        <= dz_d;
      early_q     <= early_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dz_out_q    <= dz_out_d;
      valid_q     <= valid_d;
      ready_q     <= ready_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    div_d       = div_q;
    cnt_d       = cnt_q;
    sgn_d       = sgn_q;
    neg_n_d     = neg_n_q;
    neg_diff_d  = neg_diff_q;
    dz_d        = dz_q;
    early_d     = early_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dz_out_d    = dz_out_q;
    valid_d     = valid_q;

    unique case (state_q)
      DIVSEQ_IDLE: begin
        if (start_valid) begin
          quo_d      = numer;
          div_d      = denom;
          sgn_d      = is_signed;
          neg_n_d    = numer[WIDTH-1];
          neg_diff_d = numer[WIDTH-1] ^ denom[WIDTH-1];
          state_d    = DIVSEQ_PREPARE;
        end
      end

      DIVSEQ_PREPARE: begin
        cnt_d   = CNT_W'(STEPS);
        rem_d   = '0;
        early_d = 1'b0;
        if (div_q == '0) begin
          // quo_q keeps the raw dividend for the remainder output
          dz_d    = 1'b1;
          state_d = DIVSEQ_FIXUP;
        end else begin
          dz_d    = 1'b0;
          quo_d   = abs_n_c;
          div_d   = abs_d_c;
          state_d = DIVSEQ_ITERATE;
`ifdef DIV_EARLY_OUT_EN
          // Result already known; spend a single idle Iterate cycle, no step applied.
          if (abs_d_c > abs_n_c) begin
            early_d = 1'b1;
            cnt_d   = CNT_W'(1);
            rem_d   = {1'b0, abs_n_c};
            quo_d   = '0;
          end
`endif
        end
      end

      DIVSEQ_ITERATE: begin
        if (!early_q) begin
          rem_d = step_rem_c;
          quo_d = step_quo_c;
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DIVSEQ_FIXUP;
        end
      end

      DIVSEQ_FIXUP: begin
        if (dz_q) begin
          quotient_d  = '1;
          remainder_d = quo_q;
        end else begin
          quotient_d  = (sgn_q && neg_diff_q) ? -quo_q : quo_q;
          remainder_d = (sgn_q && neg_n_q) ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
        end
        dz_out_d = dz_q;
        valid_d  = 1'b1;
        state_d  = DIVSEQ_DONE;
      end

      DIVSEQ_DONE: begin
        if (result_ready) begin
          valid_d = 1'b0;
          state_d = DIVSEQ_IDLE;
        end
      end

      default: begin
        valid_d = 1'b0;
        state_d = DIVSEQ_IDLE;
      end
    endcase

    if (flush) begin
      valid_d = 1'b0;
      state_d = DIVSEQ_IDLE;
    end

    ready_d = (state_d == DIVSEQ_IDLE);
  end

  assign start_ready    = ready_q;
  assign result_valid   = valid_q;
  assign quotient       = quotient_q;
  assign remainder      = remainder_q;
  assign divide_by_zero = dz_out_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: reference model, latency, hold, flush and reset checks.
module tb_div_sequencer;
  import div_sequencer_pkg::*;

  localparam int unsigned W = DIV_WIDTH;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic         is_signed = 1'b0;
  logic [W-1:0] numer = '0;
  logic [W-1:0] denom = '0;
  logic         flush = 1'b0;
  logic         result_valid;
  logic         result_ready = 1'b0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         divide_by_zero;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clock = ~clock;

  div_sequencer dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start_valid    (start_valid),
    .start_ready    (start_ready),
    .is_signed      (is_signed),
    .numer          (numer),
    .denom          (denom),
    .flush          (flush),
    .result_valid   (result_valid),
    .result_ready   (result_ready),
    .quotient       (quotient),
    .remainder      (remainder),
    .divide_by_zero (divide_by_zero)
  );

  task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
  endtask

  function automatic exp_t model(input logic sgn, input logic [W-1:0] n, input logic [W-1:0] d);
    exp_t         e;
    logic [W-1:0] an;
    logic [W-1:0] ad;
    logic [W-1:0] int_min;
    int_min = {1'b1, {(W-1){1'b0}}};
    e.dz  = 1'b0;
    e.lat = int'(W) + 2;
    if (d == '0) begin
      e.q   = '1;
      e.r   = n;
      e.dz  = 1'b1;
      e.lat = 2;
      return e;
    end
    if (sgn) begin
      if (n == int_min && d == '1) begin
        e.q = int_min;
        e.r = '0;
      end else begin
        e.q = W'($signed(n) / $signed(d));
        e.r = W'($signed(n) % $signed(d));
      end
    end else begin
      e.q = n / d;
      e.r = n % d;
    end
    an = (sgn && n[W-1]) ? -n : n;
    ad = (sgn && d[W-1]) ? -d : d;
`ifdef DIV_EARLY_OUT_EN
    if (ad > an) e.lat = 3;
`else
    if (ad > an) e.lat = int'(W) + 2;
`endif
    return e;
  endfunction

  task automatic run_op(input logic sgn, input logic [W-1:0] n, input logic [W-1:0] d, input int hold);
    exp_t e;
    int   lat;
    sb_q.push_back(model(sgn, n, d));
    @(negedge clock);
    check("idle_start_ready", W'(start_ready), W'(1));
    is_signed   = sgn;
    numer       = n;
    denom       = d;
    start_valid = 1'b1;
    @(posedge clock);
    #1 start_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clock);
      lat++;
      #1;
    end while (!result_valid && lat < 200);
    e = sb_q.pop_front();
    check("latency", W'(lat), W'(e.lat));
    check("quotient", quotient, e.q);
    check("remainder", remainder, e.r);
    check("div_by_zero", W'(divide_by_zero), W'(e.dz));
    for (int i = 0; i < hold; i++) begin
      @(posedge clock);
      #1;
      check("hold_valid", W'(result_valid), W'(1));
      check("hold_quotient", quotient, e.q);
      check("hold_remainder", remainder, e.r);
      check("hold_start_ready", W'(start_ready), W'(0));
    end
    result_ready = 1'b1;
    @(posedge clock);
    #1 result_ready = 1'b0;
    check("taken_valid", W'(result_valid), W'(0));
    check("taken_start_ready", W'(start_ready), W'(1));
  endtask

  initial begin
    logic seen;
    repeat (3) @(negedge clock);
    check("rst_valid", W'(result_valid), W'(0));
    check("rst_quotient", quotient, W'(0));
    check("rst_remainder", remainder, W'(0));
    check("rst_dz", W'(divide_by_zero), W'(0));
    check("rst_start_ready", W'(start_ready), W'(1));
    reset_n = 1'b1;

    run_op(1'b0, W'(100), W'(7), 0);
    run_op(1'b1, W'(-7), W'(2), 5);
    run_op(1'b1, W'(7), W'(-2), 0);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(1'b0, W'(32'h1234), W'(0), 0);
    run_op(1'b1, 32'hFFFF_FF00, W'(0), 0);

    // flush ten cycles into iteration; no result may appear
    @(negedge clock);
    is_signed = 1'b0; numer = W'(100); denom = W'(7); start_valid = 1'b1;
    @(posedge clock);
    #1 start_valid = 1'b0;
    repeat (11) @(posedge clock);
    #1 flush = 1'b1;
    @(posedge clock);
    #1 flush = 1'b0;
    check("flush_valid", W'(result_valid), W'(0));
    check("flush_start_ready", W'(start_ready), W'(1));
    seen = 1'b0;
    repeat (40) begin
      @(posedge clock);
      #1 if (result_valid) seen = 1'b1;
    end
    check("flush_no_result", W'(seen), W'(0));
    run_op(1'b0, W'(9), W'(3), 0);

    run_op(1'b0, W'(5), W'(9), 0);
    run_op(1'b1, W'(-5), W'(9), 0);
    for (int i = 0; i < 6; i++) begin
      run_op(1'($urandom_range(0, 1)), W'($urandom), W'($urandom >> $urandom_range(0, 31)), 0);
    end

    // flush beats a simultaneous start
    @(negedge clock);
    numer = W'(40); denom = W'(4); start_valid = 1'b1; flush = 1'b1;
    @(posedge clock);
    #1 start_valid = 1'b0; flush = 1'b0;
    check("flush_vs_start_ready", W'(start_ready), W'(1));

    // async reset mid-iteration drops the op and clears held outputs
    run_op(1'b0, W'(1000), W'(3), 0);
    @(negedge clock);
    numer = W'(100); denom = W'(7); start_valid = 1'b1;
    @(posedge clock);
    #1 start_valid = 1'b0;
    repeat (8) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("arst_valid", W'(result_valid), W'(0));
    check("arst_quotient", quotient, W'(0));
    check("arst_remainder", remainder, W'(0));
    check("arst_dz", W'(divide_by_zero), W'(0));
    check("arst_start_ready", W'(start_ready), W'(1));
    @(negedge clock);
    reset_n = 1'b1;
    run_op(1'b0, W'(50), W'(5), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
